mem_req_ctrl: RTL

- Request-side controller directly upstream of the synchronous memory (mem, DEPTH x WIDTH).
- Accepts read/write requests on a valid/ready channel and drives the memory's read/write/addr/data_in pins one access at a time.
- Waits the memory read latency, captures data_out and returns it on a valid/ready response channel.
- Replaces direct pin-wiggling by testbench drivers and is the front door for any future master.

---
 rtl/mem_req_ctrl_pkg.sv | 27 ++
 rtl/mem_req_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/mem_req_ctrl_pkg.sv
// Shared types and constants for the memory request controller:
// FSM state encoding, wait-counter width and the legal read-latency range.
package mem_req_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    WAIT,
    RESP
  } state_t;

  localparam int CNT_W      = 3;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 7;

  // Counter preload for a given latency, clamped so an out-of-range parameter
  // still yields a usable value instead of wrapping the 3-bit counter.
  function automatic logic [CNT_W-1:0] rd_lat_load(input int rd_lat);
    int lat;
    lat = rd_lat;
    if (lat < RD_LAT_MIN) lat = RD_LAT_MIN;
    if (lat > RD_LAT_MAX) lat = RD_LAT_MAX;
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_req_ctrl.sv
// Single-outstanding request controller in front of a synchronous memory.
// Optional write acknowledge responses: define MEM_REQ_CTRL_WR_ACK_EN.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter  int DEPTH  = 32,
  parameter  int WIDTH  = 8,
  parameter  int RD_LAT = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_is_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_data_in,
  input  logic [WIDTH-1:0]  mem_data_out
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               ready_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [WIDTH-1:0]   wdata_reg;
  logic [WIDTH-1:0]   rdata_reg;
  logic               accept;

  assign accept = (state_reg == IDLE) && req_valid && ready_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = req_write ? WR : RD;
      end
      WR: begin
`ifdef MEM_REQ_CTRL_WR_ACK_EN
        state_next = RESP;
`else
        state_next = IDLE;
`endif
      end
      RD: begin
        cnt_next   = rd_lat_load(RD_LAT);
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == '0) state_next = RESP;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ready is registered from the next state so it stays low throughout reset
  // and rises on the first clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ready_reg <= (state_next == IDLE);
      if (accept) begin
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      if (state_reg == WAIT && cnt_reg == '0) rdata_reg <= mem_data_out;
`ifdef MEM_REQ_CTRL_WR_ACK_EN
      if (state_reg == WR) rdata_reg <= '0;
`endif
    end
  end

`ifdef MEM_REQ_CTRL_WR_ACK_EN
  logic is_write_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  is_write_reg <= 1'b0;
    else if (state_reg == WR)                    is_write_reg <= 1'b1;
    else if (state_reg == WAIT && cnt_reg == '0) is_write_reg <= 1'b0;
  end

  assign rsp_is_write = is_write_reg;
`else
  assign rsp_is_write = 1'b0;
`endif

  assign req_ready   = ready_reg;
  assign rsp_valid   = (state_reg == RESP);
  assign rsp_rdata   = rdata_reg;
  assign mem_read    = (state_reg == RD);
  assign mem_write   = (state_reg == WR);
  assign mem_addr    = addr_reg;
  assign mem_data_in = wdata_reg;

endmodule
